// File: rtl/mem_pkg.sv
// Shared types for the data-memory access unit.
//   mem_op_t    : 4-bit load/store operation code presented by the MEM stage
//   mem_exc_t   : response exception code
//   mem_state_t : access FSM state encoding
//   op_is_load / op_is_store : operation class helpers. Unused codes fall in
//   neither class, so they behave as NOP.
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_LWL = 4'd6,
    OP_LWR = 4'd7,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10,
    OP_SWL = 4'd11,
    OP_SWR = 4'd12
  } mem_op_t;

  typedef enum logic [1:0] {
    EXC_NONE       = 2'd0,
    EXC_ADDR_LOAD  = 2'd1,
    EXC_ADDR_STORE = 2'd2,
    EXC_TIMEOUT    = 2'd3
  } mem_exc_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESP   = 2'd3
  } mem_state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LWR);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SWR);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data-memory access unit.
//   op         : operation code (mem_op_t encoding)
//   offset     : byte offset within the word (addr[1:0])
//   wdata      : raw store data (rt)
//   rdata      : word returned by the RAM
//   rt_old     : current rt value, merged by LWL/LWR
//   sel        : byte-lane enables, bit 3 = bits 31:24
//   lane_wdata : store data positioned on the lanes
//   load_data  : extended / merged load result
//   misaligned : halfword or word access not on its natural boundary
module mem_lane_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [3:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [3:0]  sel,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  // lane 0 always means bits 31:24. Little-endian mirrors the offset so the
  // big-endian formulas below (including LWL/LWR/SWL/SWR) apply unchanged.
  logic [1:0]  lane;
  logic [4:0]  sh_lo;    // 8 * lane
  logic [4:0]  sh_hi;    // 8 * (3 - lane)
  logic [4:0]  half_base;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign lane      = BIG_ENDIAN ? offset : (2'd3 - offset);
  assign sh_lo     = {lane, 3'b000};
  assign sh_hi     = {~lane, 3'b000};
  // Halfwords sit in the upper or lower half; lane[1] picks which, which
  // also gives the correct pairing when the offset was mirrored.
  assign half_base = {~lane[1], 4'b0000};
  assign byte_v    = rdata[sh_hi +: 8];
  assign half_v    = rdata[half_base +: 16];

  always_comb begin
    sel        = 4'b0000;
    lane_wdata = 32'h0;
    load_data  = 32'h0;
    misaligned = 1'b0;
    case (op)
      OP_LB: begin
        sel       = 4'b1111;
        load_data = {{24{byte_v[7]}}, byte_v};
      end
      OP_LBU: begin
        sel       = 4'b1111;
        load_data = {24'h0, byte_v};
      end
      OP_LH: begin
        sel        = 4'b1111;
        load_data  = {{16{half_v[15]}}, half_v};
        misaligned = offset[0];
      end
      OP_LHU: begin
        sel        = 4'b1111;
        load_data  = {16'h0, half_v};
        misaligned = offset[0];
      end
      OP_LW: begin
        sel        = 4'b1111;
        load_data  = rdata;
        misaligned = (offset != 2'b00);
      end
      OP_LWL: begin
        sel       = 4'b1111;
        load_data = (rdata << sh_lo) | (rt_old & ~(32'hFFFF_FFFF << sh_lo));
      end
      OP_LWR: begin
        sel       = 4'b1111;
        load_data = (rdata >> sh_hi) | (rt_old & ~(32'hFFFF_FFFF >> sh_hi));
      end
      OP_SB: begin
        sel        = 4'b1000 >> lane;
        lane_wdata = {4{wdata[7:0]}};
      end
      OP_SH: begin
        sel        = 4'b1100 >> {lane[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        misaligned = offset[0];
      end
      OP_SW: begin
        sel        = 4'b1111;
        lane_wdata = wdata;
        misaligned = (offset != 2'b00);
      end
      OP_SWL: begin
        sel        = 4'b1111 >> lane;
        lane_wdata = wdata >> sh_lo;
      end
      OP_SWR: begin
        sel        = 4'b1111 << (~lane);
        lane_wdata = wdata << sh_hi;
      end
      default: begin
        sel = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit between the CPU MEM stage and the data RAM.
// Accepts one load/store per valid/ready handshake, runs a variable-latency
// RAM cycle, and returns a single-cycle response with data or an exception.
//   clock, reset        : clock and asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_op/addr/wdata/rt_old : operation, byte address, store data, old rt
//   flush               : abort current operation, suppress its response
//   resp_valid/data/exc : one-cycle completion pulse, load data, exception
//   ram_en/we/sel/addr/wdata, ram_rdata/ram_ack : RAM request/acknowledge
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | RAM request outstanding, waiting for ram_ack or timeout
// DRAIN  | flushed while outstanding; finish the RAM cycle silently
// RESP   | present the response for one cycle
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [31:0]           req_rt_old,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic [1:0]            resp_exc,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [3:0]            ram_sel,
  output logic [ADDR_WIDTH-3:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_ack
);

  // Counter must be able to hold TIMEOUT_CYCLES after the final increment.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  mem_state_t            state_q, state_d;
  logic [3:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           rt_q;
  logic [3:0]            sel_q;
  logic [31:0]           lane_wdata_q;
  logic                  we_q;
  logic [31:0]           rdata_q;
  mem_exc_t              exc_q;
  logic [CW-1:0]         cnt_q;

  logic                  accept;
  logic                  is_nop;
  logic                  timeout_hit;
  logic                  busy;

  logic [3:0]            al_op;
  logic [1:0]            al_off;
  logic [3:0]            al_sel;
  logic [31:0]           al_lane_wdata;
  logic [31:0]           al_load_data;
  logic                  al_misaligned;

  // In IDLE the aligner looks at the incoming request (lanes and fault are
  // captured at accept); afterwards it works on the captured operation so
  // the load merge sees stable op/offset/rt_old.
  assign al_op  = (state_q == S_IDLE) ? req_op        : op_q;
  assign al_off = (state_q == S_IDLE) ? req_addr[1:0] : addr_q[1:0];

  mem_lane_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_align (
    .op         (al_op),
    .offset     (al_off),
    .wdata      (req_wdata),
    .rdata      (ram_rdata),
    .rt_old     (rt_q),
    .sel        (al_sel),
    .lane_wdata (al_lane_wdata),
    .load_data  (al_load_data),
    .misaligned (al_misaligned)
  );

  assign accept      = (state_q == S_IDLE) && req_valid && !flush;
  assign is_nop      = !op_is_load(req_op) && !op_is_store(req_op);
  assign timeout_hit = (cnt_q == TO_LAST);
  assign busy        = (state_q == S_ACCESS) || (state_q == S_DRAIN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (is_nop || al_misaligned) ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Ack wins over flush: the RAM cycle completes, only the response
        // is dropped.
        if (ram_ack || timeout_hit) begin
          state_d = flush ? S_IDLE : S_RESP;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ram_ack || timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q         <= OP_NOP;
      addr_q       <= '0;
      rt_q         <= '0;
      sel_q        <= '0;
      lane_wdata_q <= '0;
      we_q         <= 1'b0;
      rdata_q      <= '0;
      exc_q        <= EXC_NONE;
      cnt_q        <= '0;
    end else if (accept) begin
      op_q         <= req_op;
      addr_q       <= req_addr;
      rt_q         <= req_rt_old;
      sel_q        <= al_sel;
      lane_wdata_q <= al_lane_wdata;
      we_q         <= op_is_store(req_op);
      rdata_q      <= '0;
      cnt_q        <= '0;
      if (!al_misaligned) begin
        exc_q <= EXC_NONE;
      end else if (op_is_store(req_op)) begin
        exc_q <= EXC_ADDR_STORE;
      end else begin
        exc_q <= EXC_ADDR_LOAD;
      end
    end else if (busy) begin
      if (ram_ack) begin
        if ((state_q == S_ACCESS) && op_is_load(op_q)) begin
          rdata_q <= al_load_data;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
        if (timeout_hit) begin
          exc_q <= EXC_TIMEOUT;
        end
      end
    end
  end

  // Outputs decode straight from the state register so an asynchronous
  // reset clears them immediately, without waiting for a clock edge.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    ram_en     = busy;
    ram_we     = 1'b0;
    ram_sel    = '0;
    ram_addr   = '0;
    ram_wdata  = '0;
    resp_valid = (state_q == S_RESP) && !flush;
    resp_data  = '0;
    resp_exc   = EXC_NONE;
    if (busy) begin
      ram_we    = we_q;
      ram_sel   = sel_q;
      ram_addr  = addr_q[ADDR_WIDTH-1:2];
      ram_wdata = lane_wdata_q;
    end
    if (resp_valid) begin
      resp_data = rdata_q;
      resp_exc  = exc_q;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_rt_old = 32'h0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_exc;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        ram_ack = 1'b0;

  mem_access_unit #(
    .ADDR_WIDTH     (32),
    .BIG_ENDIAN     (1'b1),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rt_old (req_rt_old),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_exc   (resp_exc),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_sel    (ram_sel),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ack    (ram_ack)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ram_mem [16];

  int          obs_en_first;
  int          obs_en_cnt;
  int          obs_resp_cyc;
  logic        obs_got_resp;
  logic        obs_done;
  logic [3:0]  obs_sel;
  logic [31:0] obs_wdata;
  logic        obs_we;
  logic [29:0] obs_addr;
  logic [31:0] obs_data;
  logic [1:0]  obs_exc;

  // One transaction: request, RAM responder (ack after wait_n wait states,
  // never if wait_n < 0), optional flush in cycle flush_at. Cycle 1 is the
  // first cycle after the accept edge.
  task automatic xact(input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rt,
                      input int wait_n, input int flush_at);
    int cyc;
    int waits;
    obs_en_first = -1; obs_en_cnt = 0; obs_resp_cyc = -1;
    obs_got_resp = 1'b0; obs_done = 1'b0;
    obs_sel = 4'h0; obs_wdata = 32'h0; obs_we = 1'b0; obs_addr = 30'h0;
    obs_data = 32'h0; obs_exc = 2'd0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt_old = rt;
    @(posedge clock); #1;
    req_valid = 1'b0; req_op = 4'd0;
    waits = 0;
    cyc = 1;
    while (!obs_done && cyc <= 60) begin
      flush = (cyc == flush_at);
      ram_ack = 1'b0;
      if (ram_en) begin
        if (obs_en_first < 0) obs_en_first = cyc;
        obs_en_cnt++;
        obs_sel = ram_sel; obs_wdata = ram_wdata; obs_we = ram_we; obs_addr = ram_addr;
        if (wait_n >= 0 && waits == wait_n) begin
          ram_ack = 1'b1;
          ram_rdata = ram_mem[ram_addr[3:0]];
          if (ram_we)
            for (int b = 0; b < 4; b++)
              if (ram_sel[b]) ram_mem[ram_addr[3:0]][8*b +: 8] = ram_wdata[8*b +: 8];
        end else begin
          waits++;
        end
      end
      #1;
      if (resp_valid) begin
        obs_got_resp = 1'b1; obs_resp_cyc = cyc; obs_data = resp_data; obs_exc = resp_exc;
      end
      if (cyc >= 2 && req_ready && !ram_en && !resp_valid) obs_done = 1'b1;
      if (!obs_done) begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    ram_ack = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
    n_checks++; if (ram_en !== 1'b0) $display("FAIL reset_ram_en got %b want 0", ram_en); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== 32'h0) $display("FAIL reset_resp_data got %h want 0", resp_data); else n_pass++;
    n_checks++; if (ram_sel !== 4'h0 || ram_we !== 1'b0 || ram_wdata !== 32'h0)
      $display("FAIL reset_ram_outs got sel %b we %b wdata %h want all 0", ram_sel, ram_we, ram_wdata); else n_pass++;
  endtask

  task automatic test_byte();
    xact(OP_SB, 32'd3, 32'h0000_00FF, 32'h0, 0, -1);
    n_checks++; if (obs_sel !== 4'b0001) $display("FAIL sb3_sel got %b want 0001", obs_sel); else n_pass++;
    n_checks++; if (obs_wdata !== 32'hFFFF_FFFF) $display("FAIL sb3_wdata got %h want ffffffff", obs_wdata); else n_pass++;
    n_checks++; if (obs_we !== 1'b1 || obs_addr !== 30'd0) $display("FAIL sb3_we_addr got %b %0d want 1 0", obs_we, obs_addr); else n_pass++;
    n_checks++; if (obs_en_first !== 1 || obs_resp_cyc !== 2) $display("FAIL sb3_latency got en %0d resp %0d want 1 2", obs_en_first, obs_resp_cyc); else n_pass++;
    n_checks++; if (obs_exc !== 2'd0 || obs_data !== 32'h0) $display("FAIL sb3_resp got exc %0d data %h want 0 0", obs_exc, obs_data); else n_pass++;
    xact(OP_SB, 32'd2, 32'h0000_00EE, 32'h0, 0, -1);
    n_checks++; if (obs_sel !== 4'b0010) $display("FAIL sb2_sel got %b want 0010", obs_sel); else n_pass++;
    n_checks++; if (ram_mem[0][15:0] !== 16'hEEFF) $display("FAIL sb_word0 got %h want xxxxeeff", ram_mem[0]); else n_pass++;
    xact(OP_LBU, 32'd2, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_data !== 32'h0000_00EE) $display("FAIL lbu2 got %h want 000000ee", obs_data); else n_pass++;
    xact(OP_LB, 32'd3, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_data !== 32'hFFFF_FFFF) $display("FAIL lb3 got %h want ffffffff", obs_data); else n_pass++;
  endtask

  task automatic test_half_word();
    xact(OP_SH, 32'd6, 32'h0000_8899, 32'h0, 0, -1);
    n_checks++; if (obs_sel !== 4'b0011) $display("FAIL sh6_sel got %b want 0011", obs_sel); else n_pass++;
    n_checks++; if (obs_wdata !== 32'h8899_8899 || obs_addr !== 30'd1) $display("FAIL sh6_wdata got %h @%0d want 88998899 @1", obs_wdata, obs_addr); else n_pass++;
    xact(OP_LH, 32'd6, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_data !== 32'hFFFF_8899) $display("FAIL lh6 got %h want ffff8899", obs_data); else n_pass++;
    xact(OP_LHU, 32'd6, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_data !== 32'h0000_8899) $display("FAIL lhu6 got %h want 00008899", obs_data); else n_pass++;
    xact(OP_SW, 32'd8, 32'h4455_6677, 32'h0, 0, -1);
    n_checks++; if (obs_sel !== 4'b1111 || obs_addr !== 30'd2) $display("FAIL sw8 got sel %b @%0d want 1111 @2", obs_sel, obs_addr); else n_pass++;
    xact(OP_LW, 32'd8, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_data !== 32'h4455_6677) $display("FAIL lw8 got %h want 44556677", obs_data); else n_pass++;
  endtask

  task automatic test_unaligned();
    xact(OP_LWL, 32'd9, 32'h0, 32'hAABB_CCDD, 0, -1);
    n_checks++; if (obs_data !== 32'h5566_77DD) $display("FAIL lwl9 got %h want 556677dd", obs_data); else n_pass++;
    xact(OP_LWR, 32'd9, 32'h0, 32'hAABB_CCDD, 0, -1);
    n_checks++; if (obs_data !== 32'hAABB_4455) $display("FAIL lwr9 got %h want aabb4455", obs_data); else n_pass++;
    xact(OP_SWL, 32'd9, 32'hAABB_CCDD, 32'h0, 0, -1);
    n_checks++; if (obs_sel !== 4'b0111 || obs_wdata !== 32'h00AA_BBCC) $display("FAIL swl9 got sel %b wdata %h want 0111 00aabbcc", obs_sel, obs_wdata); else n_pass++;
    xact(OP_LW, 32'd8, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_data !== 32'h44AA_BBCC) $display("FAIL swl9_word got %h want 44aabbcc", obs_data); else n_pass++;
    xact(OP_SWR, 32'd9, 32'hAABB_CCDD, 32'h0, 0, -1);
    n_checks++; if (obs_sel !== 4'b1100 || obs_wdata !== 32'hCCDD_0000) $display("FAIL swr9 got sel %b wdata %h want 1100 ccdd0000", obs_sel, obs_wdata); else n_pass++;
  endtask

  task automatic test_align_fault();
    xact(OP_LH, 32'd1, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_exc !== 2'd1) $display("FAIL lh1_exc got %0d want 1", obs_exc); else n_pass++;
    n_checks++; if (obs_resp_cyc !== 1 || obs_en_cnt !== 0) $display("FAIL lh1_timing got resp %0d en %0d want 1 0", obs_resp_cyc, obs_en_cnt); else n_pass++;
    n_checks++; if (obs_data !== 32'h0) $display("FAIL lh1_data got %h want 0", obs_data); else n_pass++;
    xact(OP_SW, 32'd2, 32'h1234_5678, 32'h0, 0, -1);
    n_checks++; if (obs_exc !== 2'd2 || obs_en_cnt !== 0) $display("FAIL sw2_exc got %0d en %0d want 2 0", obs_exc, obs_en_cnt); else n_pass++;
    xact(OP_NOP, 32'd5, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_resp_cyc !== 1 || obs_en_cnt !== 0 || obs_exc !== 2'd0) $display("FAIL nop got resp %0d en %0d exc %0d want 1 0 0", obs_resp_cyc, obs_en_cnt, obs_exc); else n_pass++;
    xact(4'd14, 32'd8, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_resp_cyc !== 1 || obs_en_cnt !== 0) $display("FAIL op14_nop got resp %0d en %0d want 1 0", obs_resp_cyc, obs_en_cnt); else n_pass++;
  endtask

  task automatic test_wait_states();
    xact(OP_LW, 32'd8, 32'h0, 32'h0, 3, -1);
    n_checks++; if (obs_resp_cyc - obs_en_first !== 4) $display("FAIL wait3_latency got %0d want 4", obs_resp_cyc - obs_en_first); else n_pass++;
    n_checks++; if (obs_data !== 32'hCCDD_BBCC) $display("FAIL wait3_data got %h want ccddbbcc", obs_data); else n_pass++;
    xact(OP_LW, 32'd8, 32'h0, 32'h0, -1, -1);
    n_checks++; if (obs_en_cnt !== 16) $display("FAIL timeout_en_cycles got %0d want 16", obs_en_cnt); else n_pass++;
    n_checks++; if (obs_exc !== 2'd3 || obs_resp_cyc !== 17) $display("FAIL timeout_resp got exc %0d at %0d want 3 at 17", obs_exc, obs_resp_cyc); else n_pass++;
    n_checks++; if (obs_data !== 32'h0) $display("FAIL timeout_data got %h want 0", obs_data); else n_pass++;
  endtask

  task automatic test_flush();
    xact(OP_LW, 32'd0, 32'h0, 32'h0, 4, 2);
    n_checks++; if (obs_en_cnt !== 5) $display("FAIL flush_drain_en got %0d want 5", obs_en_cnt); else n_pass++;
    n_checks++; if (obs_got_resp !== 1'b0) $display("FAIL flush_no_resp got %b want 0", obs_got_resp); else n_pass++;
    n_checks++; if (obs_done !== 1'b1 || req_ready !== 1'b1) $display("FAIL flush_idle got done %b ready %b want 1 1", obs_done, req_ready); else n_pass++;
    xact(OP_LW, 32'd8, 32'h0, 32'h0, 0, 1);
    n_checks++; if (obs_got_resp !== 1'b0 || obs_en_cnt !== 1) $display("FAIL flush_with_ack got resp %b en %0d want 0 1", obs_got_resp, obs_en_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    xact(OP_LBU, 32'd3, 32'h0, 32'h0, 1, -1);
    n_checks++; if (obs_data !== 32'h0000_00FF || obs_resp_cyc !== 3) $display("FAIL b2b_first got %h at %0d want 000000ff at 3", obs_data, obs_resp_cyc); else n_pass++;
    xact(OP_LHU, 32'd10, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_data !== 32'h0000_BBCC) $display("FAIL b2b_second got %h want 0000bbcc", obs_data); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'd8;
    @(posedge clock); #1;
    req_valid = 1'b0; req_op = 4'd0;
    n_checks++; if (ram_en !== 1'b1) $display("FAIL rst_mid_pre_en got %b want 1", ram_en); else n_pass++;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    n_checks++; if (ram_en !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_mid_async got en %b ready %b want 0 1", ram_en, req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0 || ram_sel !== 4'h0 || ram_addr !== 30'h0) $display("FAIL rst_mid_outs got rv %b sel %b addr %h want 0", resp_valid, ram_sel, ram_addr); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (resp_valid !== 1'b0 || ram_en !== 1'b0) $display("FAIL rst_mid_after got rv %b en %b want 0 0", resp_valid, ram_en); else n_pass++;
    xact(OP_LW, 32'd8, 32'h0, 32'h0, 0, -1);
    n_checks++; if (obs_data !== 32'hCCDD_BBCC) $display("FAIL rst_mid_recover got %h want ccddbbcc", obs_data); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram_mem[i] = 32'h0;
    #2;
    reset = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    test_byte();
    test_half_word();
    test_unaligned();
    test_align_fault();
    test_wait_states();
    test_flush();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised data-memory access unit between the CPU MEM stage and the data RAM.
- Executes all MIPS load/store forms: LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW/SWL/SWR.
- Replaces the fixed single-cycle RAM path with a valid/ready request, a variable-latency RAM handshake (ram_ack), alignment exceptions, a bus timeout and flush support.

Parameters:
- ADDR_WIDTH, 32, byte address width; RAM word address is ADDR_WIDTH-2 bits.
- BIG_ENDIAN, 1, 1 = MIPS big-endian lane order; 0 = little-endian (byte offset o maps to lane 3-o).
- TIMEOUT_CYCLES, 16, maximum cycles in ACCESS waiting for ram_ack before BUS_TIMEOUT; minimum 1.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  MEM stage presents an operation.
- req_ready  out  1  unit accepts an operation; high only in IDLE.
- req_op  in  4  mem_op_t operation code.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data (rt).
- req_rt_old  in  32  current rt value, merged by LWL/LWR.
- flush  in  1  abort the current operation and suppress its response.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  load result; 0 for stores and exceptions.
- resp_exc  out  2  mem_exc_t: NONE, ADDR_LOAD, ADDR_STORE, TIMEOUT.
- ram_en  out  1  RAM request, held until ram_ack.
- ram_we  out  1  write enable.
- ram_sel  out  4  byte-lane enables; bit 3 = bits 31:24.
- ram_addr  out  ADDR_WIDTH-2  word address.
- ram_wdata  out  32  lane-positioned write data.
- ram_rdata  in  32  read data, valid with ram_ack.
- ram_ack  in  1  RAM completes the access this cycle.

Behaviour:
- Reset (reset = 0):
  - State goes to IDLE and the timeout counter to 0.
  - All outputs are 0 except req_ready = 1.
  - Reset asserted during ACCESS drops ram_en immediately; no response is produced.
- FSM states: IDLE, ACCESS, DRAIN, RESP.
- IDLE:
  - Capture op/addr/wdata/rt_old when req_valid && req_ready.
  - If the access is misaligned (H: o[0] != 0; W: o != 0), go to RESP with resp_exc = ADDR_LOAD or ADDR_STORE. No RAM cycle is issued.
  - LWL/LWR/SWL/SWR never fault.
  - NOP is accepted and goes straight to RESP with no RAM cycle.
  - Otherwise go to ACCESS.
- ACCESS:
  - ram_en = 1; ram_we/ram_sel/ram_addr/ram_wdata are stable from registered values.
  - ram_ack high in the same cycle completes the access. Loads register the merged result. Next state is RESP.
  - The counter increments on each cycle without ack. When it reaches TIMEOUT_CYCLES, ram_en drops and the unit goes to RESP with TIMEOUT.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. req_ready is low in RESP.
- Latency:
  - Accept edge, then ram_en in the next cycle.
  - Zero-wait ack gives resp_valid one cycle later.
  - Each wait state adds one cycle.
  - A faulting access gives resp_valid in the cycle after accept.
- Flush:
  - IDLE or RESP: the pending response is dropped and the unit returns to IDLE.
  - ACCESS: go to DRAIN. ram_en stays high until ram_ack (or timeout), then return to IDLE with no resp_valid.
  - Flush simultaneous with ram_ack: the access completes and the response is suppressed.
- Lane rules (big-endian; o = addr[1:0]):
  - SB: sel = 4'b1000 >> o; wdata = byte replicated x4.
  - SH: sel = 4'b1100 >> o; wdata = half replicated x2.
  - SW: sel = 1111; wdata = rt.
  - SWL: sel = 4'b1111 >> o; wdata = rt >> 8o.
  - SWR: sel = (4'b1111 << (3-o)) truncated to 4 bits; wdata = rt << 8(3-o).
  - LB/LBU: byte at lane o, sign- or zero-extended. LH/LHU: same for halfwords. LW: whole word.
  - LWL: (mem << 8o) | (rt_old & ((1 << 8o) - 1)).
  - LWR: (mem >> 8(3-o)) | (rt_old & ~(32'hFFFFFFFF >> 8(3-o))).
  - BIG_ENDIAN = 0 uses o' = 3 - o for lane selection.
- Unused op codes are treated as NOP.

Decomposition:
- Package mem_pkg holds:
  - mem_op_t (4-bit: NOP, LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR).
  - mem_exc_t.
  - fsm state encoding.
- One combinational sub-module, mem_lane_align, computes sel/wdata for stores, the load extract/merge, and the misalignment flag from (op, o, wdata, rdata, rt_old).
- The FSM, counter and registers live in mem_access_unit.

Test Plan:
- Stores and byte loads:
  - SB 0xFF @3, then SB 0xEE @2 -> ram_sel 0001 then 0010; RAM word0 = 0x????EEFF.
  - LBU @2 -> resp_data 0x000000EE. LB @3 -> 0xFFFFFFFF.
- Halfword and word: SH 0x8899 @6 -> sel 0011. LH @6 -> 0xFFFF8899; LHU @6 -> 0x00008899. SW 0x44556677 @8, then LW @8 -> 0x44556677.
- Unaligned loads: mem 0x44556677 @8 with rt_old 0xAABBCCDD:
  - LWL @9 -> 0x556677DD.
  - LWR @9 -> 0xAABB4455.
  - SWL @9 with rt 0xAABBCCDD -> sel 0111, wdata 0x00AABBCC.
- Alignment fault: LH @1 -> resp_exc ADDR_LOAD one cycle after accept, ram_en never high, resp_data 0. SW @2 -> ADDR_STORE.
- Wait states and timeout:
  - ram_ack delayed 3 cycles -> resp_valid exactly 4 cycles after ram_en rises, with correct data.
  - ram_ack never asserted, TIMEOUT_CYCLES = 16 -> ram_en drops and resp_exc = TIMEOUT.
- Flush and reset:
  - Flush in the 2nd wait state -> ram_en held until ack, no resp_valid, req_ready returns to 1.
  - reset = 0 mid-ACCESS -> all outputs 0 and req_ready = 1 immediately, without waiting for a clock edge.
